// File: rtl/id_fwd_stage_pkg.sv
// Shared decode constants for the id_fwd_stage slice: opcodes, NOP encoding,
// enable levels and immediate helpers.
package id_fwd_stage_pkg;

  typedef enum logic [6:0] {
    INST_TYPE_I     = 7'b0010011,
    INST_TYPE_R_M   = 7'b0110011,
    INST_TYPE_LUI   = 7'b0110111,
    INST_TYPE_AUIPC = 7'b0010111,
    INST_TYPE_LOAD  = 7'b0000011
  } opcode_e;

  localparam logic [31:0] NOP           = 32'h0000_0013;
  localparam logic [31:0] ZERO          = 32'h0000_0000;
  localparam logic        READ_ENABLE   = 1'b1;
  localparam logic        READ_DISABLE  = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

  function automatic logic [31:0] upper_imm(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/id_fwd_stage_mux.sv
// Operand source select for one regfile read port: x0, youngest matching
// forwarding source, or regfile data; flags a hazard on a pending match.
module id_fwd_stage_mux #(
  parameter int FWD_STAGES  = 2,
  parameter int RADDR_WIDTH = 5,
  parameter int DATA_WIDTH  = 32
) (
  input  logic [RADDR_WIDTH-1:0]            raddr_i,
  input  logic                              re_i,
  input  logic [DATA_WIDTH-1:0]             rdata_i,
  input  logic [FWD_STAGES-1:0]             fwd_we_i,
  input  logic [FWD_STAGES*RADDR_WIDTH-1:0] fwd_waddr_i,
  input  logic [FWD_STAGES*DATA_WIDTH-1:0]  fwd_wdata_i,
  input  logic [FWD_STAGES-1:0]             fwd_pending_i,
  output logic [DATA_WIDTH-1:0]             data_o,
  output logic                              hazard_o
);

  always_comb begin
    data_o   = rdata_i;
    hazard_o = 1'b0;
    // Walk oldest to youngest so the lowest index overrides every older match.
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (fwd_we_i[k] && (fwd_waddr_i[k*RADDR_WIDTH +: RADDR_WIDTH] == raddr_i)) begin
        data_o   = fwd_pending_i[k] ? '0 : fwd_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        hazard_o = fwd_pending_i[k];
      end
    end
    if (!re_i || (raddr_i == '0)) begin
      data_o   = '0;
      hazard_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_fwd_stage.sv
// Decode stage with operand forwarding, load-use stall and the registered
// id->exe boundary (valid/ready).
module id_fwd_stage
  import id_fwd_stage_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int FWD_STAGES  = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [ADDR_WIDTH-1:0]             inst_addr_i,
  input  logic [DATA_WIDTH-1:0]             inst_i,
  output logic [RADDR_WIDTH-1:0]            reg1_raddr_o,
  output logic [RADDR_WIDTH-1:0]            reg2_raddr_o,
  output logic                              reg1_re_o,
  output logic                              reg2_re_o,
  input  logic [DATA_WIDTH-1:0]             reg1_rdata_i,
  input  logic [DATA_WIDTH-1:0]             reg2_rdata_i,
  input  logic [FWD_STAGES-1:0]             fwd_we_i,
  input  logic [FWD_STAGES*RADDR_WIDTH-1:0] fwd_waddr_i,
  input  logic [FWD_STAGES*DATA_WIDTH-1:0]  fwd_wdata_i,
  input  logic [FWD_STAGES-1:0]             fwd_pending_i,
  input  logic                              flush_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [DATA_WIDTH-1:0]             inst_o,
  output logic [ADDR_WIDTH-1:0]             inst_addr_o,
  output logic [DATA_WIDTH-1:0]             op1_o,
  output logic [DATA_WIDTH-1:0]             op2_o,
  output logic                              reg_we_o,
  output logic [RADDR_WIDTH-1:0]            reg_waddr_o,
  output logic [CNT_WIDTH-1:0]              hazard_cnt_o
);

  logic [RADDR_WIDTH-1:0] rs1, rs2, rd;
  logic                   dec_re1, dec_re2, dec_we;
  logic [RADDR_WIDTH-1:0] dec_waddr;
  logic [DATA_WIDTH-1:0]  op1_imm, op2_imm;
  logic [DATA_WIDTH-1:0]  rs1_data, rs2_data;
  logic                   rs1_hazard, rs2_hazard;
  logic                   hazard, accept;
  logic [DATA_WIDTH-1:0]  dec_op1, dec_op2;

  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  inst_q, inst_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  op1_q, op1_d;
  logic [DATA_WIDTH-1:0]  op2_q, op2_d;
  logic                   we_q, we_d;
  logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  assign rs1 = RADDR_WIDTH'(inst_i[19:15]);
  assign rs2 = RADDR_WIDTH'(inst_i[24:20]);
  assign rd  = RADDR_WIDTH'(inst_i[11:7]);

  // Immediate-only operands come from op*_imm; enabled reads take the mux output.
  always_comb begin
    dec_re1   = READ_DISABLE;
    dec_re2   = READ_DISABLE;
    dec_we    = WRITE_DISABLE;
    dec_waddr = '0;
    op1_imm   = DATA_WIDTH'(ZERO);
    op2_imm   = DATA_WIDTH'(ZERO);
    case (opcode_e'(inst_i[6:0]))
      INST_TYPE_I, INST_TYPE_LOAD: begin
        dec_re1   = READ_ENABLE;
        dec_we    = WRITE_ENABLE;
        dec_waddr = rd;
        op2_imm   = DATA_WIDTH'(sext12(inst_i[31:20]));
      end
      INST_TYPE_R_M: begin
        dec_re1   = READ_ENABLE;
        dec_re2   = READ_ENABLE;
        dec_we    = WRITE_ENABLE;
        dec_waddr = rd;
      end
      INST_TYPE_LUI: begin
        dec_we    = WRITE_ENABLE;
        dec_waddr = rd;
        op1_imm   = DATA_WIDTH'(upper_imm(32'(inst_i)));
      end
      INST_TYPE_AUIPC: begin
        dec_we    = WRITE_ENABLE;
        dec_waddr = rd;
        op1_imm   = DATA_WIDTH'(inst_addr_i);
        op2_imm   = DATA_WIDTH'(upper_imm(32'(inst_i)));
      end
      default: ;
    endcase
  end

  assign reg1_re_o    = dec_re1;
  assign reg2_re_o    = dec_re2;
  assign reg1_raddr_o = dec_re1 ? rs1 : '0;
  assign reg2_raddr_o = dec_re2 ? rs2 : '0;

  id_fwd_stage_mux #(
    .FWD_STAGES (FWD_STAGES),
    .RADDR_WIDTH(RADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux_op1 (
    .raddr_i      (reg1_raddr_o),
    .re_i         (dec_re1),
    .rdata_i      (reg1_rdata_i),
    .fwd_we_i     (fwd_we_i),
    .fwd_waddr_i  (fwd_waddr_i),
    .fwd_wdata_i  (fwd_wdata_i),
    .fwd_pending_i(fwd_pending_i),
    .data_o       (rs1_data),
    .hazard_o     (rs1_hazard)
  );

  id_fwd_stage_mux #(
    .FWD_STAGES (FWD_STAGES),
    .RADDR_WIDTH(RADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux_op2 (
    .raddr_i      (reg2_raddr_o),
    .re_i         (dec_re2),
    .rdata_i      (reg2_rdata_i),
    .fwd_we_i     (fwd_we_i),
    .fwd_waddr_i  (fwd_waddr_i),
    .fwd_wdata_i  (fwd_wdata_i),
    .fwd_pending_i(fwd_pending_i),
    .data_o       (rs2_data),
    .hazard_o     (rs2_hazard)
  );

  always_comb begin
    dec_op1    = dec_re1 ? rs1_data : op1_imm;
    dec_op2    = dec_re2 ? rs2_data : op2_imm;
    hazard     = rs1_hazard || rs2_hazard;
    in_ready_o = !hazard && !flush_i && (!valid_q || out_ready_i);
    accept     = in_valid_i && in_ready_o;

    valid_d = valid_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      inst_d  = inst_i;
      addr_d  = inst_addr_i;
      op1_d   = dec_op1;
      op2_d   = dec_op2;
      we_d    = dec_we;
      waddr_d = dec_waddr;
    end else if (out_ready_i && valid_q) begin
      valid_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (in_valid_i && hazard && !flush_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      inst_q  <= DATA_WIDTH'(NOP);
      addr_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = addr_q;
  assign op1_o        = op1_q;
  assign op2_o        = op2_q;
  assign reg_we_o     = we_q;
  assign reg_waddr_o  = waddr_q;
  assign hazard_cnt_o = cnt_q;

endmodule
